key_input: RTL

Debounced, arbitrated push-button front end that sits directly upstream of the `simon` game core. It takes the four raw, active-low `KEY` buttons, synchronises and debounces them, and reports single-button press events with the button index. Multi-button chords are rejected, and a release pulse marks the point where the core may arm for the next input. The core consumes `press_valid`/`press_code` instead of sampling `KEY` directly.

---
 rtl/key_input.sv | 135 +++++++++++++
 1 files changed

// File: rtl/key_input.sv
// Push-button front end for the simon core: synchronises and debounces four
// active-low keys, then arbitrates them into single-press / release / chord pulses.

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic s,
  output logic stable
);
  logic [CNT_W-1:0] cnt;

  // Any return to the stable level restarts qualification from zero.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (s == stable) begin
      cnt    <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable <= s;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

module key_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] KEY,
  output logic [3:0] key_stable,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic       release_pulse,
  output logic       multi_press,
  output logic       all_released
);
  localparam int NUM_KEYS = 4;

  typedef enum logic [1:0] {IDLE, PRESSED, INVALID} state_t;

  logic [NUM_KEYS-1:0] sync1, sync2, s;
  state_t              state, state_nx;
  logic [1:0]          code_nx, hot_idx;
  logic [NUM_KEYS-1:0] code_mask;
  logic                pv_nx, rp_nx, mp_nx;

  // Synchroniser resets to "released" so leaving reset never looks like a press.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_db
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .s       (s[gi]),
      .stable  (key_stable[gi])
    );
  end

  always_comb begin
    hot_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (key_stable[i]) hot_idx = 2'(i);
    code_mask = 4'b0001 << press_code;
    state_nx  = state;
    code_nx   = press_code;
    pv_nx     = 1'b0;
    rp_nx     = 1'b0;
    mp_nx     = 1'b0;
    case (state)
      IDLE: begin
        if ($onehot(key_stable)) begin
          state_nx = PRESSED;
          code_nx  = hot_idx;
          pv_nx    = 1'b1;
        end else if (key_stable != '0) begin
          state_nx = INVALID;
          mp_nx    = 1'b1;
        end
      end
      PRESSED: begin
        if (key_stable == '0) begin
          state_nx = IDLE;
          rp_nx    = 1'b1;
        end else if ((key_stable & ~code_mask) != '0) begin
          // A foreign key spoils the press even if the original let go this cycle.
          state_nx = INVALID;
          mp_nx    = 1'b1;
        end
      end
      INVALID: begin
        if (key_stable == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      press_code    <= '0;
      press_valid   <= 1'b0;
      release_pulse <= 1'b0;
      multi_press   <= 1'b0;
      all_released  <= 1'b1;
    end else begin
      state         <= state_nx;
      press_code    <= code_nx;
      press_valid   <= pv_nx;
      release_pulse <= rp_nx;
      multi_press   <= mp_nx;
      all_released  <= (key_stable == '0);
    end
  end
endmodule
